// File: rtl/mmio_console_if.sv
// Store-bus snoop and console byte-stream bundle for mmio_console.
// master = core/consumer side, slave = the console sink.
interface mmio_console_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (output MemWrite, DataAdr, WriteData, tx_ready,
                  input  tx_valid, tx_data);
  modport slave  (input  MemWrite, DataAdr, WriteData, tx_ready,
                  output tx_valid, tx_data);
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console FIFO + sticky tohost result, snooping the dmem store bus.
// Optional macro MMIO_CYCLE_COUNT_EN: snapshot a cycle counter into 'cycles' when done sets.
module mmio_console #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_0400,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0404,
  parameter logic [31:0] PASS_VALUE   = 32'd1,
  parameter int          DEPTH        = 8
) (
  input  logic           clk,
  input  logic           reset,
  mmio_console_if.slave  bus,
  output logic           fifo_full,
  output logic [7:0]     drop_count,
  output logic           done,
  output logic           pass,
  output logic [31:0]    cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          cons_st, host_st, push, pop;

  assign cons_st = bus.MemWrite && (bus.DataAdr == CONSOLE_ADDR);
  assign host_st = bus.MemWrite && (bus.DataAdr == TOHOST_ADDR);
  assign pop     = (count != '0) && bus.tx_ready;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push    = cons_st && ((count != CNT_FULL) || pop);

  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = mem[rd_ptr];
  assign fifo_full    = (count == CNT_FULL);

  // Storage is deliberately not reset; count gates visibility.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.WriteData[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cons_st && !push && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
    end
  end

  // First tohost store wins; later ones are ignored until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (host_st && !done) begin
      done <= 1'b1;
      pass <= (bus.WriteData == PASS_VALUE);
    end
  end

`ifdef MMIO_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      cycles  <= '0;
    end else begin
      if (cyc_cnt != 32'hFFFF_FFFF) cyc_cnt <= cyc_cnt + 32'd1;
      if (host_st && !done) cycles <= cyc_cnt;
    end
  end
`else
  assign cycles = 32'd0;
`endif

endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped output sink that sits directly downstream of the core's data-memory port, in parallel with dmem.
- Snoops the store bus (MemWrite, DataAdr, WriteData) and decodes two fixed addresses:
  - Console address: stores push bytes into a FIFO, drained by a valid/ready byte consumer (UART model or bench).
  - Tohost address: stores latch a sticky done/pass result for simulation and board bring-up.
- Never drives ReadData; dmem still sees every store.

Parameters:
- CONSOLE_ADDR, 32'h0000_0400, full 32-bit byte address of the console register.
- TOHOST_ADDR, 32'h0000_0404, full 32-bit byte address of the test-result register.
- PASS_VALUE, 32'd1, tohost value that signals pass.
- DEPTH, 8, FIFO depth in bytes; power of two, 2..64.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- MemWrite  input  1  store strobe from core
- DataAdr  input  32  store byte address from core
- WriteData  input  32  store data from core
- tx_valid  output  1  FIFO head byte available
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  consumer accepts the head byte this cycle
- fifo_full  output  1  FIFO holds DEPTH bytes
- drop_count  output  8  bytes lost to overflow, saturating
- done  output  1  sticky; a tohost store has occurred
- pass  output  1  valid when done=1; first tohost value == PASS_VALUE
- cycles  output  32  cycle count snapshot (see Optional Feature)

Behaviour:
- Decode is an exact 32-bit compare. No masking or alignment check.
- A console store is MemWrite && DataAdr==CONSOLE_ADDR. A tohost store is MemWrite && DataAdr==TOHOST_ADDR.
- Console push:
  - Writes WriteData[7:0] at the write pointer; WriteData[31:8] is ignored.
  - Push accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Pop occurs when tx_valid && tx_ready; the read pointer advances.
- First-word fall-through:
  - tx_valid = (count!=0).
  - tx_data = mem[rd_ptr], combinational from registered state.
  - A byte pushed at edge N is visible on tx_valid/tx_data after edge N, i.e. one-cycle latency.
- tx_data is don't-care when tx_valid=0. The bench must only check it when tx_valid=1.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle with count in 1..DEPTH: count unchanged, both pointers advance.
- Push and pop in the same cycle with count==0: push only, since tx_valid=0 means no pop.
- Rejected push (full, no pop): byte is discarded; drop_count increments, saturating at 8'hFF.
- fifo_full = (count==DEPTH).
- Tohost store while done==0: done<=1, pass<=(WriteData==PASS_VALUE).
- Tohost store while done==1: ignored; the first result wins.
- done and pass never clear except on reset.
- Console and tohost stores are mutually exclusive by address. No other address has any effect.
- Reset values: tx_valid=0, fifo_full=0, drop_count=0, done=0, pass=0, cycles=0.
  - Pointers and count are 0.
  - FIFO storage contents are not reset.
- Reset asserted mid-stream flushes the FIFO on that edge; pending bytes are lost.
- MemWrite is sampled only at the clock edge; glitches between edges are irrelevant.

Optional Feature:
- Macro: MMIO_CYCLE_COUNT_EN.
- Defined:
  - A 32-bit free-running counter increments every cycle after reset deasserts and saturates at 32'hFFFF_FFFF.
  - On the edge that sets done, cycles latches the counter value, then holds.
  - Before done, cycles reads 0.
- Undefined:
  - No counter is built; cycles is tied to 32'd0.
  - The port still exists so top-level wiring is identical.

Test Plan:
- Reset, then store 0x0000_0041 to CONSOLE_ADDR with tx_ready=1 -> next cycle tx_valid=1, tx_data=8'h41; following cycle tx_valid=0.
- tx_ready=0; store bytes 0x01..0x0A (10 stores, DEPTH=8) -> fifo_full=1 after the 8th; drop_count=2. Then raise tx_ready -> pops 0x01..0x08 in order, then tx_valid=0.
- Fill to 8 bytes; in one cycle store 0x55 with tx_ready=1 -> count stays 8, head advances, 0x55 is delivered last, drop_count unchanged.
- Store 1 to TOHOST_ADDR, then store 2 -> done=1, pass=1, unchanged by the second store. Separate run storing 0xDEAD -> done=1, pass=0.
- Load 3 bytes, pulse reset one cycle -> tx_valid=0, drop_count=0, done=0. New store 0x7A -> delivered as the only byte.
- With MMIO_CYCLE_COUNT_EN, tohost store on cycle 20 after reset release -> cycles=20 and holds. Without the macro -> cycles=0.
